// File: rtl/fp_pipe_pkg.sv
// Shared constants and the IEEE-754 result packer for the floating-point adder pipeline.
// The drain, its result FIFO and the testbench all import this package.
package fp_pipe_pkg;

    localparam int PIPE_DEPTH = 5;

    localparam logic MODE_DBL = 1'b1;
    localparam logic MODE_SGL = 1'b0;

    localparam int FRAC_LANE1_BASE = 26;
    localparam int FRAC_LANE0_BASE = 0;
    localparam int EXPO_SPLIT      = 8;

    localparam int SGL_FRAC_W = 23;
    localparam int SGL_EXPO_W = 8;
    localparam int DBL_EXPO_W = 11;

    localparam int WORD_W  = 64;
    localparam int ENTRY_W = WORD_W + 1;

    // Lane 1 fills the upper 32 bits and lane 0 the lower 32 bits.
    // Fraction bits 51:49 and 25:23 are padding in packed-single mode.
    function automatic logic [WORD_W-1:0] pack_result(
        input logic        mode,
        input logic [1:0]  signs,
        input logic [15:0] expo,
        input logic [51:0] frac
    );
        logic [WORD_W-1:0] word;
        if (mode == MODE_DBL) begin
            word = {signs[0], expo[DBL_EXPO_W-1:0], frac};
        end else begin
            word = {signs[1], expo[EXPO_SPLIT +: SGL_EXPO_W], frac[FRAC_LANE1_BASE +: SGL_FRAC_W],
                    signs[0], expo[0 +: SGL_EXPO_W],          frac[FRAC_LANE0_BASE +: SGL_FRAC_W]};
        end
        return word;
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous result FIFO with an asynchronous active-low clear.
// DEPTH must be a power of two so that the read and write pointers wrap naturally.
module fp_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not cleared; entries are only visible once the count says they exist.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_drain.sv
// Output-side drain of the FP adder pipeline: tracks live slots, owns the shared stage enable,
// packs each finished result into an IEEE-754 word and buffers it for a valid/ready consumer.
module fp_result_drain #(
    parameter int PIPE_DEPTH = fp_pipe_pkg::PIPE_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_in_valid,
    output logic        o_pipe_en,
    input  logic        ou_mode,
    input  logic [1:0]  ou_Ls,
    input  logic [15:0] ou_res_expo,
    input  logic [51:0] ou_res_frac,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_result,
    output logic        o_mode,
    output logic        o_busy
);
    import fp_pipe_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PIPE_DEPTH-1:0] vld;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    rd_entry;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Only stall when the output stage holds a real result with nowhere to go; bubbles always drain.
    assign o_pipe_en = !fifo_full || !vld[PIPE_DEPTH-1];
    assign push      = vld[PIPE_DEPTH-1] && o_pipe_en;
    assign pop       = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_clr) begin
        if (!i_clr) begin
            vld <= '0;
        end else if (o_pipe_en) begin
            vld <= {vld[PIPE_DEPTH-2:0], i_in_valid};
        end
    end

    assign wr_entry = {ou_mode, pack_result(ou_mode, ou_Ls, ou_res_expo, ou_res_frac)};

    fp_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_clr),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Outputs are forced to zero while empty so stale storage never leaks out after a clear.
    assign o_valid  = !fifo_empty;
    assign o_result = o_valid ? rd_entry[WORD_W-1:0] : '0;
    assign o_mode   = o_valid ? rd_entry[WORD_W] : MODE_SGL;
    assign o_busy   = (|vld) || (fifo_count != '0);

endmodule
